// File: rtl/hist_pkg.sv
// Shared types, widths and address helper for the histogram readout master.
package hist_pkg;

  localparam int unsigned HIST_DATA_W = 32;
  localparam int unsigned HIST_ADDR_W = 32;
  localparam int unsigned HIST_IDX_W  = 8;

  localparam logic [HIST_DATA_W-1:0] HIST_TIMEOUT_FILL = 32'h0;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    PUSH,
    CLEAR,
    DONE
  } rd_state_t;

  // Bin address; wraps modulo 2^32.
  function automatic logic [HIST_ADDR_W-1:0] bin_addr(
    input logic [HIST_ADDR_W-1:0] base,
    input logic [HIST_IDX_W-1:0]  idx,
    input logic [HIST_ADDR_W-1:0] stride
  );
    return base + (HIST_ADDR_W'(idx) * stride);
  endfunction

endpackage

// File: rtl/hist_readout_master_if.sv
// Register-bus request/response plus bin-count stream seen by the readout master.
interface hist_readout_master_if;
  import hist_pkg::*;

  logic [HIST_ADDR_W-1:0] m_addr;
  logic                   m_read;
  logic                   m_write;
  logic [HIST_DATA_W-1:0] m_writedata;
  logic [HIST_DATA_W-1:0] s_readdata;
  logic                   s_readvalid;
  logic [HIST_DATA_W-1:0] out_data;
  logic [HIST_IDX_W-1:0]  out_idx;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output m_addr, m_read, m_write, m_writedata,
    output out_data, out_idx, out_valid,
    input  s_readdata, s_readvalid, out_ready
  );

  modport slave (
    input  m_addr, m_read, m_write, m_writedata,
    input  out_data, out_idx, out_valid,
    output s_readdata, s_readvalid, out_ready
  );

endinterface

// File: rtl/hist_wait_timer.sv
// Clear/enable cycle counter with a terminal count at TIMEOUT_CYCLES-1.
module hist_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc_c = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/hist_readout_master.sv
// Sweeps histogram bins over the register bus and streams each count out.
// HIST_CLEAR_ON_READ_EN: write 0 back to each bin after it has been streamed.
module hist_readout_master
  import hist_pkg::*;
#(
  parameter int unsigned            NUM_BINS       = 3,
  parameter logic [HIST_ADDR_W-1:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [HIST_ADDR_W-1:0] ADDR_STRIDE    = 32'd1,
  parameter int unsigned            TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic timeout_err,
  hist_readout_master_if.master bus
);

  rd_state_t              state;
  logic [HIST_IDX_W-1:0]  idx;
  logic [HIST_IDX_W-1:0]  idx_next_c;
  logic [HIST_ADDR_W-1:0] next_addr_c;
  logic                   last_bin_c;
  logic                   tmr_clr_c;
  logic                   tmr_en_c;
  logic                   tmr_tc_c;

  assign idx_next_c  = idx + HIST_IDX_W'(1);
  assign next_addr_c = bin_addr(BASE_ADDR, idx_next_c, ADDR_STRIDE);
  assign last_bin_c  = (idx == HIST_IDX_W'(NUM_BINS - 1));

  // Timer only advances while waiting on a missing response.
  assign tmr_clr_c = (state == ISSUE);
  assign tmr_en_c  = (state == WAIT) && !bus.s_readvalid && !tmr_tc_c;

  hist_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr_c),
    .en  (tmr_en_c),
    .tc_c(tmr_tc_c)
  );

  assign bus.m_writedata = '0;

`ifndef HIST_CLEAR_ON_READ_EN
  assign bus.m_write = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout_err   <= 1'b0;
      bus.m_addr    <= '0;
      bus.m_read    <= 1'b0;
      bus.out_data  <= '0;
      bus.out_idx   <= '0;
      bus.out_valid <= 1'b0;
`ifdef HIST_CLEAR_ON_READ_EN
      bus.m_write   <= 1'b0;
`endif
    end else begin
      bus.m_read <= 1'b0;
      done       <= 1'b0;
`ifdef HIST_CLEAR_ON_READ_EN
      bus.m_write <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            idx         <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            bus.m_addr  <= bin_addr(BASE_ADDR, HIST_IDX_W'(0), ADDR_STRIDE);
            bus.m_read  <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (bus.s_readvalid) begin
            bus.out_data  <= bus.s_readdata;
            bus.out_idx   <= idx;
            bus.out_valid <= 1'b1;
            state         <= PUSH;
          end else if (tmr_tc_c) begin
            bus.out_data  <= HIST_TIMEOUT_FILL;
            bus.out_idx   <= idx;
            bus.out_valid <= 1'b1;
            timeout_err   <= 1'b1;
            state         <= PUSH;
          end
        end
        PUSH: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
`ifdef HIST_CLEAR_ON_READ_EN
            bus.m_write   <= 1'b1;
            state         <= CLEAR;
`else
            if (last_bin_c) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx        <= idx_next_c;
              bus.m_addr <= next_addr_c;
              bus.m_read <= 1'b1;
              state      <= ISSUE;
            end
`endif
          end
        end
        // m_addr still points at the bin just streamed during the clear write.
        CLEAR: begin
          if (last_bin_c) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx        <= idx_next_c;
            bus.m_addr <= next_addr_c;
            bus.m_read <= 1'b1;
            state      <= ISSUE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hist_readout_master.md
Name: hist_readout_master

Overview:
Bus initiator that drains histogram bin counts over the m_/s_ register interface the histogram core responds on.
- On a start pulse, issues one read per bin, waits for the read-valid response (with timeout) and streams each count out on a valid/ready port.
- Sits between the histogram core's register port and downstream logging/upload logic; replaces manual JTAG polling.

Parameters:
NUM_BINS, 3, number of bins read per sweep; legal range 1..256.
BASE_ADDR, 32'h0000_0000, address of bin 0.
ADDR_STRIDE, 1, address increment between consecutive bins.
TIMEOUT_CYCLES, 16, max cycles spent in WAIT for s_readvalid; minimum 2.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
start  in  1  single-cycle sweep request.
busy  out  1  high from the cycle after an accepted start until DONE exits.
done  out  1  one-cycle pulse when the sweep completes.
m_addr  out  32  request address.
m_read  out  1  one-cycle read strobe.
m_write  out  1  one-cycle write strobe (used only by the optional feature).
m_writedata  out  32  write data.
s_readdata  in  32  read response data.
s_readvalid  in  1  read response qualifier.
out_data  out  32  bin count.
out_idx  out  8  bin index of out_data.
out_valid  out  1  stream valid.
out_ready  in  1  stream ready.
timeout_err  out  1  sticky; set if any read in the sweep timed out.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; idx=0; timer=0.
- Reset mid-sweep aborts immediately; no further strobes are issued.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: if start=1, then idx<=0, timeout_err<=0, go to ISSUE. start in any other state is ignored.
  - ISSUE: m_read=1 for exactly one cycle; m_addr=BASE_ADDR+idx*ADDR_STRIDE (32-bit, wraps modulo 2^32); timer<=0; go to WAIT.
  - WAIT:
    - If s_readvalid=1, capture s_readdata into out_data and go to PUSH.
    - Otherwise timer++. When timer reaches TIMEOUT_CYCLES-1 with no valid: out_data<=32'h0, timeout_err<=1, go to PUSH.
    - Latency: the earliest response is accepted one cycle after the m_read cycle.
  - PUSH: out_valid=1 and out_idx=idx; out_data/out_idx stay stable until out_ready=1.
    - On handshake: go to CLEAR if the feature is enabled; otherwise go to DONE if idx==NUM_BINS-1, else idx++ and go to ISSUE.
  - DONE: done=1 for one cycle; go to IDLE.
- s_readvalid outside WAIT is ignored (no capture, no error). A late response after a timeout is dropped.
- m_addr holds its last value between requests. m_writedata=0 always.
- m_read and m_write are never high in the same cycle.
- NUM_BINS=1: a single read, then DONE.
- busy=1 in ISSUE, WAIT, PUSH, CLEAR and DONE.

Optional Feature:
Macro HIST_CLEAR_ON_READ_EN.
- Defined: adds a CLEAR state after each PUSH handshake. In CLEAR, m_write=1 for one cycle, with m_addr equal to the bin just read and m_writedata=0. Then DONE if idx==NUM_BINS-1, else idx++ and ISSUE. This gives read-and-clear sweeps.
- Undefined: no CLEAR state; m_write is tied to 0.

Decomposition:
- Package hist_pkg holds:
  - rd_state_t enum: IDLE, ISSUE, WAIT, PUSH, CLEAR, DONE.
  - HIST_DATA_W=32, HIST_ADDR_W=32.
  - HIST_TIMEOUT_FILL=32'h0.
- One sub-module, hist_wait_timer: clear/enable counter with a terminal-count output at TIMEOUT_CYCLES-1.

Test Plan:
- NUM_BINS=3, responder returns 5, 9, 12 two cycles after each m_read, out_ready=1 -> m_addr sequence 0,1,2; stream (0,5),(1,9),(2,12); done pulses once; timeout_err=0.
- Responder silent for bin 1, TIMEOUT_CYCLES=16 -> WAIT lasts 16 cycles; stream (1,0); timeout_err=1 stays set until the next start.
- out_ready low for 5 cycles on bin 0 -> out_valid held, out_data=5 stable, no new m_read until the handshake.
- Assert rst during WAIT of bin 1, then start again -> all outputs 0 after reset; the new sweep begins at m_addr=0; no stale data is emitted.
- start pulsed while busy, plus a spurious s_readvalid in IDLE -> both ignored; exactly NUM_BINS reads per sweep.
- HIST_CLEAR_ON_READ_EN defined, BASE_ADDR=0x10, ADDR_STRIDE=4 -> sequence: read 0x10, write 0x10 (data 0), read 0x14, write 0x14, ...
